// File: rtl/regfile32_wr.sv
// ---------------------------------------------------------------------------
// regfile32_wr
//   32 x DATA_W LEGv8 register file with two combinational read ports and one
//   synchronous write port. The 5-bit write address is decoded in two levels:
//   a 2:4 bank decoder on WriteRegister[4:3], qualified by RegWrite, enables
//   four 3:8 decoders on WriteRegister[2:0]. Together they form a one-hot
//   32-bit row write-enable. Register ZERO_REG (XZR) always reads zero and
//   ignores writes.
//
// Ports
//   clk            rising-edge clock for all state
//   reset          synchronous, active-low; clears every row and wr_onehot
//   RegWrite       write strobe from the writeback stage
//   WriteRegister  destination index
//   WriteData      value to write
//   ReadRegister1  source index, port A
//   ReadRegister2  source index, port B
//   ReadData1      contents of ReadRegister1 (combinational)
//   ReadData2      contents of ReadRegister2 (combinational)
//   wr_onehot      registered write-enable of the previous edge, XZR bit masked
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a write in flight is forwarded to any read
//                      port that addresses the same (non-XZR) register in the
//                      same cycle. When undefined, reads return stored rows.
// ---------------------------------------------------------------------------
module regfile32_wr #(
  parameter int DATA_W   = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [4:0]        WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadRegister1,
  input  logic [4:0]        ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [31:0]       wr_onehot
);

  localparam logic [4:0] ZERO_IDX = ZERO_REG[4:0];

  logic [3:0]        bank_en;
  logic [31:0]       we;
  logic [DATA_W-1:0] rows [NREGS];

  // First decode level: bank select, gated by the write strobe.
  // NOTE: every signal driven in always_comb gets a default before any
  // conditional assignment, so no path leaves it unassigned (no latch).
  always_comb begin
    bank_en = '0;
    for (int b = 0; b < 4; b++) begin
      bank_en[b] = RegWrite && (WriteRegister[4:3] == 2'(b));
    end
  end

  // Second decode level: four 3:8 decoders, each enabled by one bank line.
  // The result is one-hot while RegWrite is high and zero otherwise.
  always_comb begin
    we = '0;
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 8; j++) begin
        we[b*8 + j] = bank_en[b] && (WriteRegister[2:0] == 3'(j));
      end
    end
  end

  // Row storage. Reset wins over a simultaneous write, so a write whose edge
  // sees reset low never lands in any row.
  // NOTE: the whole array is cleared by reset because the architecture
  // requires every register to read zero after reset; this keeps the rows in
  // flops rather than a RAM macro, which is intended for a 32-entry file.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NREGS; k++) begin
        // NOTE: sequential state uses non-blocking assignments so every row
        // updates from pre-edge values, independent of statement order.
        rows[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        if (we[k] && (k != ZERO_REG)) begin
          rows[k] <= WriteData;
        end
      end
    end
  end

  // Debug copy of the decoded enable, one cycle late, XZR bit masked off.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_onehot <= '0;
    end else begin
      wr_onehot <= we & ~(32'd1 << ZERO_IDX);
    end
  end

  // Read muxes. XZR is forced to zero here so it never depends on row state.
  always_comb begin
    ReadData1 = (ReadRegister1 == ZERO_IDX) ? '0 : rows[ReadRegister1];
    ReadData2 = (ReadRegister2 == ZERO_IDX) ? '0 : rows[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
    // Forward the write in flight; suppressed during reset since that write
    // is dropped, and for XZR which never takes a value.
    if (RegWrite && reset && (WriteRegister != ZERO_IDX)) begin
      if (WriteRegister == ReadRegister1) ReadData1 = WriteData;
      if (WriteRegister == ReadRegister2) ReadData2 = WriteData;
    end
`endif
  end

endmodule

// File: tb/tb_regfile32_wr.sv
// ---------------------------------------------------------------------------
// tb_regfile32_wr
//   Self-checking bench for regfile32_wr. Each scenario task pushes expected
//   values to a scoreboard queue when it drives stimulus, then pops and
//   compares them when the DUT output is sampled (#1 after the rising edge,
//   or mid-cycle for combinational reads).
// ---------------------------------------------------------------------------
module tb_regfile32_wr;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              RegWrite;
  logic [4:0]        WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [4:0]        ReadRegister1;
  logic [4:0]        ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [31:0]       wr_onehot;

  regfile32_wr #(.DATA_W(DATA_W), .NREGS(32), .ZERO_REG(31)) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .wr_onehot     (wr_onehot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] exp;
    string             tag;
  } exp_t;

  exp_t expq [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [63:0] STEP = 64'h0101_0101_0101_0101;

  // Plain write cycle helper (stimulus only, no checks).
  task automatic do_write(input logic [4:0] idx, input logic [63:0] val);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = idx;
    WriteData     = val;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  task automatic push(input logic [63:0] v, input string t);
    exp_t e;
    e.exp = v;
    e.tag = t;
    expq.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    // Power-on reset
    reset = 1'b0;
    RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    // Write X5, then pull reset low for one edge.
    do_write(5'd5, 64'hDEAD_BEEF_0000_0001);
    @(negedge clk);
    reset = 1'b0;
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd0;
    push(64'd0, "reset_rd1_x5");
    push(64'd0, "reset_rd2_x0");
    push(64'd0, "reset_onehot");
    @(posedge clk);
    #1;
    reset = 1'b1;
    e = expq.pop_front(); n_checks++;
    if (ReadData1 !== e.exp) $display("FAIL %s: got %h expected %h", e.tag, ReadData1, e.exp);
    else n_pass++;
    e = expq.pop_front(); n_checks++;
    if (ReadData2 !== e.exp) $display("FAIL %s: got %h expected %h", e.tag, ReadData2, e.exp);
    else n_pass++;
    e = expq.pop_front(); n_checks++;
    if (wr_onehot !== e.exp[31:0]) $display("FAIL %s: got %h expected %h", e.tag, wr_onehot, e.exp[31:0]);
    else n_pass++;
  endtask

  task automatic test_walking_write();
    exp_t e;
    for (int k = 0; k < 31; k++) begin
      logic [63:0] v;
      v = STEP * 64'(k);
      @(negedge clk);
      RegWrite      = 1'b1;
      WriteRegister = 5'(k);
      WriteData     = v;
      ReadRegister1 = 5'(k);
      ReadRegister2 = 5'(k);
      push(v, "walk_rd1");
      push(v, "walk_rd2");
      push(64'(32'd1 << k), "walk_onehot");
      @(posedge clk);
      #1;
      RegWrite = 1'b0;
      #1;
      e = expq.pop_front(); n_checks++;
      if (ReadData1 !== e.exp) $display("FAIL %s[%0d]: got %h expected %h", e.tag, k, ReadData1, e.exp);
      else n_pass++;
      e = expq.pop_front(); n_checks++;
      if (ReadData2 !== e.exp) $display("FAIL %s[%0d]: got %h expected %h", e.tag, k, ReadData2, e.exp);
      else n_pass++;
      e = expq.pop_front(); n_checks++;
      if (wr_onehot !== e.exp[31:0]) $display("FAIL %s[%0d]: got %h expected %h", e.tag, k, wr_onehot, e.exp[31:0]);
      else n_pass++;
    end
    // Re-read everything with no write in flight, two different indices per port.
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      ReadRegister1 = 5'(k);
      ReadRegister2 = 5'(30 - k);
      push(STEP * 64'(k), "readback_rd1");
      push(STEP * 64'(30 - k), "readback_rd2");
      #1;
      e = expq.pop_front(); n_checks++;
      if (ReadData1 !== e.exp) $display("FAIL %s[%0d]: got %h expected %h", e.tag, k, ReadData1, e.exp);
      else n_pass++;
      e = expq.pop_front(); n_checks++;
      if (ReadData2 !== e.exp) $display("FAIL %s[%0d]: got %h expected %h", e.tag, k, ReadData2, e.exp);
      else n_pass++;
    end
  endtask

  task automatic test_xzr();
    exp_t e;
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd31;
    WriteData     = 64'hFFFF_FFFF_FFFF_FFFF;
    ReadRegister1 = 5'd31;
    ReadRegister2 = 5'd31;
    push(64'd0, "xzr_pre_rd2");
    push(64'd0, "xzr_rd1");
    push(64'd0, "xzr_onehot");
    #1;
    e = expq.pop_front(); n_checks++;
    if (ReadData2 !== e.exp) $display("FAIL %s: got %h expected %h", e.tag, ReadData2, e.exp);
    else n_pass++;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    e = expq.pop_front(); n_checks++;
    if (ReadData1 !== e.exp) $display("FAIL %s: got %h expected %h", e.tag, ReadData1, e.exp);
    else n_pass++;
    e = expq.pop_front(); n_checks++;
    if (wr_onehot !== e.exp[31:0]) $display("FAIL %s: got %h expected %h", e.tag, wr_onehot, e.exp[31:0]);
    else n_pass++;
  endtask

  task automatic test_regwrite_low();
    exp_t e;
    do_write(5'd7, 64'h1234);
    @(negedge clk);
    RegWrite      = 1'b0;
    WriteRegister = 5'd7;
    WriteData     = 64'hAAAA;
    ReadRegister1 = 5'd7;
    ReadRegister2 = 5'd7;
    for (int n = 0; n < 3; n++) begin
      push(64'h1234, "rw0_rd1");
      push(64'd0, "rw0_onehot");
      @(posedge clk);
      #1;
      e = expq.pop_front(); n_checks++;
      if (ReadData1 !== e.exp) $display("FAIL %s[%0d]: got %h expected %h", e.tag, n, ReadData1, e.exp);
      else n_pass++;
      e = expq.pop_front(); n_checks++;
      if (wr_onehot !== e.exp[31:0]) $display("FAIL %s[%0d]: got %h expected %h", e.tag, n, wr_onehot, e.exp[31:0]);
      else n_pass++;
    end
  endtask

  task automatic test_same_cycle_hazard();
    exp_t e;
    do_write(5'd9, 64'h11);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = 5'd9;
    WriteData     = 64'h22;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd9;
`ifdef REGFILE_BYPASS_EN
    push(64'h22, "hazard_pre");
`else
    push(64'h11, "hazard_pre");
`endif
    push(64'h22, "hazard_post");
    #1;
    e = expq.pop_front(); n_checks++;
    if (ReadData2 !== e.exp) $display("FAIL %s: got %h expected %h", e.tag, ReadData2, e.exp);
    else n_pass++;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    #1;
    e = expq.pop_front(); n_checks++;
    if (ReadData2 !== e.exp) $display("FAIL %s: got %h expected %h", e.tag, ReadData2, e.exp);
    else n_pass++;
  endtask

  task automatic test_reset_write_collision();
    exp_t e;
    do_write(5'd3, 64'h77);
    @(negedge clk);
    reset         = 1'b0;
    RegWrite      = 1'b1;
    WriteRegister = 5'd3;
    WriteData     = 64'h55;
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd9;
    push(64'd0, "collide_x3");
    push(64'd0, "collide_x9");
    push(64'd0, "collide_onehot");
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    reset    = 1'b1;
    #1;
    e = expq.pop_front(); n_checks++;
    if (ReadData1 !== e.exp) $display("FAIL %s: got %h expected %h", e.tag, ReadData1, e.exp);
    else n_pass++;
    e = expq.pop_front(); n_checks++;
    if (ReadData2 !== e.exp) $display("FAIL %s: got %h expected %h", e.tag, ReadData2, e.exp);
    else n_pass++;
    e = expq.pop_front(); n_checks++;
    if (wr_onehot !== e.exp[31:0]) $display("FAIL %s: got %h expected %h", e.tag, wr_onehot, e.exp[31:0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_walking_write();
    test_xzr();
    test_regwrite_low();
    test_same_cycle_hazard();
    test_reset_write_collision();
    n_checks++;
    if (expq.size() != 0) $display("FAIL scoreboard_drain: got %0d left expected 0", expq.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
